// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32 multi-cycle control unit and its datapath:
// opcodes, ALU operation codes, the sequencer state enum and instruction classes.
package ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_JAL, CLS_JALR, CLS_LUI, CLS_BAD
  } class_t;

  function automatic class_t opcode_class(input logic [6:0] opcode);
    case (opcode)
      OP_R:    return CLS_R;
      OP_I:    return CLS_I;
      OP_LW:   return CLS_LW;
      OP_SW:   return CLS_SW;
      OP_BEQ:  return CLS_BEQ;
      OP_JAL:  return CLS_JAL;
      OP_JALR: return CLS_JALR;
      OP_LUI:  return CLS_LUI;
      default: return CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an instruction class plus funct3/funct7[5] to the ALU operation and
// flags encodings the control unit does not support.
import ctrl_pkg::*;

module alu_decoder (
  input  class_t      cls,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output logic [3:0]  aluctl,
  output logic        legal
);

  always_comb begin
    aluctl = ALU_AND;
    legal  = 1'b1;
    case (cls)
      CLS_R: begin
        case (funct3)
          3'b000:  aluctl = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  aluctl = ALU_AND;
          3'b110:  aluctl = ALU_OR;
          3'b010:  aluctl = ALU_SLT;
          default: legal  = 1'b0;
        endcase
      end
      CLS_I: begin
        case (funct3)
          3'b000:  aluctl = ALU_ADD;
          3'b111:  aluctl = ALU_AND;
          3'b110:  aluctl = ALU_OR;
          3'b010:  aluctl = ALU_SLT;
          default: legal  = 1'b0;
        endcase
      end
      CLS_LW, CLS_SW: aluctl = ALU_ADD;
      CLS_BEQ: begin
        aluctl = ALU_SUB;
        legal  = (funct3 == 3'b000);
      end
      CLS_JAL, CLS_JALR, CLS_LUI: aluctl = ALU_AND;
      default: legal = 1'b0;
    endcase
    if (!legal) aluctl = ALU_AND;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32 datapath: FETCH/DECODE/EXEC/MEM/WB with
// control outputs decoded from fields latched at the end of FETCH.
import ctrl_pkg::*;

module multicycle_control #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instruction,
  input  logic         zero,
  output logic         ir_en,
  output logic         pc_en,
  output logic         branch,
  output logic         mem2reg,
  output logic         memwrite,
  output logic         alusrc,
  output logic         regwrite,
  output logic         pcsrc,
  output logic [3:0]   aluctl,
  output logic         illegal,
  output logic [2:0]   state,
  output logic [W-1:0] instret
);

  state_t       state_q, state_d;
  logic [6:0]   opcode_q;
  logic [2:0]   funct3_q;
  logic         funct7_5_q;
  logic [W-1:0] instret_q;
  class_t       cls;
  logic [3:0]   dec_aluctl;
  logic         dec_legal;
  logic         unused_bits;

  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};
  assign cls = opcode_class(opcode_q);

  alu_decoder u_alu_decoder (
    .cls      (cls),
    .funct3   (funct3_q),
    .funct7_5 (funct7_5_q),
    .aluctl   (dec_aluctl),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  // Later states decode only from these, so the live instruction bus may change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_q   <= 7'd0;
      funct3_q   <= 3'd0;
      funct7_5_q <= 1'b0;
    end else if (state_q == FETCH) begin
      opcode_q   <= instruction[6:0];
      funct3_q   <= instruction[14:12];
      funct7_5_q <= instruction[30];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  instret_q <= '0;
    else if (pc_en && !illegal) instret_q <= instret_q + W'(1);
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (!dec_legal)          state_d = FETCH;
        else if (cls == CLS_LUI) state_d = WB;
        else                     state_d = EXEC;
      end
      EXEC: begin
        case (cls)
          CLS_R, CLS_I:   state_d = WB;
          CLS_LW, CLS_SW: state_d = MEM;
          default:        state_d = FETCH;
        endcase
      end
      MEM:     state_d = (cls == CLS_LW) ? WB : FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    branch   = 1'b0;
    mem2reg  = 1'b0;
    memwrite = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    pcsrc    = 1'b0;
    aluctl   = ALU_AND;
    illegal  = 1'b0;
    case (state_q)
      FETCH:  ir_en = 1'b1;
      DECODE: begin
        illegal = !dec_legal;
        pc_en   = !dec_legal;
      end
      EXEC: begin
        aluctl = dec_aluctl;
        alusrc = (cls == CLS_I) || (cls == CLS_LW) || (cls == CLS_SW);
        branch = (cls == CLS_BEQ);
        pcsrc  = (cls == CLS_JAL) || ((cls == CLS_BEQ) && zero);
        pc_en  = (cls == CLS_BEQ) || (cls == CLS_JAL) || (cls == CLS_JALR);
      end
      MEM: begin
        aluctl   = dec_aluctl;
        alusrc   = 1'b1;
        memwrite = (cls == CLS_SW);
        pc_en    = (cls == CLS_SW);
      end
      WB: begin
        aluctl   = dec_aluctl;
        alusrc   = (cls == CLS_I) || (cls == CLS_LW);
        mem2reg  = (cls == CLS_LW);
        regwrite = 1'b1;
        pc_en    = 1'b1;
      end
      default: ir_en = 1'b0;
    endcase
    // Reset kills every output immediately so an in-flight write never lands.
    if (!rst) begin
      ir_en    = 1'b0;
      pc_en    = 1'b0;
      branch   = 1'b0;
      mem2reg  = 1'b0;
      memwrite = 1'b0;
      alusrc   = 1'b0;
      regwrite = 1'b0;
      pcsrc    = 1'b0;
      aluctl   = ALU_AND;
      illegal  = 1'b0;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: reset checks, a latency/result vector table,
// hand-written corner sequences and random instructions against a sequence model.
module tb_multicycle_control;

  logic        clk, rst, zero;
  logic [31:0] instruction;
  logic        ir_en, pc_en, branch, mem2reg, memwrite, alusrc, regwrite, pcsrc, illegal;
  logic [3:0]  aluctl;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [15:0] dut_vec;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_instret = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic        z;
    int          cyc;
    logic [3:0]  alu;
    logic        pcs;
    logic        ill;
    logic        wr;
  } vec_t;

  vec_t vecs[18];

  multicycle_control #(.W(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .ir_en(ir_en), .pc_en(pc_en), .branch(branch), .mem2reg(mem2reg),
    .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite), .pcsrc(pcsrc),
    .aluctl(aluctl), .illegal(illegal), .state(state), .instret(instret)
  );

  // Packed view: state[15:13] ir_en pc_en branch mem2reg memwrite alusrc regwrite pcsrc illegal aluctl[3:0]
  assign dut_vec = {state, ir_en, pc_en, branch, mem2reg, memwrite, alusrc,
                    regwrite, pcsrc, illegal, aluctl};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected per-cycle outputs for one instruction, from its class sequence and per-class rules.
  task automatic model_push(input logic [31:0] ins, input logic z);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7, ok, late, last;
    logic       is_r, is_i, is_lw, is_sw, is_beq, is_jal, is_jalr, is_lui;
    logic [3:0] op;
    logic [2:0] st;
    int         seq[5];
    int         n;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[30];
    is_r = (opc == 7'h33); is_i = (opc == 7'h13); is_lw = (opc == 7'h03);
    is_sw = (opc == 7'h23); is_beq = (opc == 7'h63); is_jal = (opc == 7'h6F);
    is_jalr = (opc == 7'h67); is_lui = (opc == 7'h37);
    op = 4'h0; ok = 1'b1;
    if (is_r || is_i) begin
      if (f3 == 3'd0)      op = (is_r && f7) ? 4'h6 : 4'h2;
      else if (f3 == 3'd7) op = 4'h0;
      else if (f3 == 3'd6) op = 4'h1;
      else if (f3 == 3'd2) op = 4'h7;
      else                 ok = 1'b0;
    end else if (is_lw || is_sw) op = 4'h2;
    else if (is_beq) begin
      op = 4'h6;
      ok = (f3 == 3'd0);
    end else if (!(is_jal || is_jalr || is_lui)) ok = 1'b0;
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 4;
    if (!ok) n = 2;
    else if (is_lui) begin n = 3; seq[2] = 4; end
    else if (is_beq || is_jal || is_jalr) n = 3;
    else if (is_lw) n = 5;
    else if (is_sw) n = 4;
    else begin n = 4; seq[3] = 4; end
    for (int k = 0; k < n; k++) begin
      st = seq[k][2:0];
      last = (k == n - 1);
      late = (st >= 3'd2);
      exp_q.push_back({st, st == 3'd0, last, is_beq && st == 3'd2, is_lw && st == 3'd4,
                       is_sw && st == 3'd3, (is_i || is_lw || is_sw) && late, st == 3'd4,
                       st == 3'd2 && (is_jal || (is_beq && z)), !ok && st == 3'd1,
                       late ? op : 4'h0});
    end
  endtask

  // Runs one table vector from FETCH; must be called just after a rising edge.
  task automatic apply_vec(input vec_t v, input int idx);
    int   n;
    logic done, wrote;
    instruction = v.instr; zero = v.z;
    n = 0; done = 1'b0; wrote = 1'b0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check($sformatf("fetch_state[%0d]", idx), state, 0);
        check($sformatf("fetch_ir_en[%0d]", idx), ir_en, 1);
      end
      if (regwrite || memwrite) wrote = 1'b1;
      if (pc_en) begin
        done = 1'b1;
        check($sformatf("aluctl[%0d]", idx), aluctl, v.alu);
        check($sformatf("pcsrc[%0d]", idx), pcsrc, v.pcs);
        check($sformatf("illegal[%0d]", idx), illegal, v.ill);
      end
      @(posedge clk); #1;
    end
    if (!v.ill) exp_instret++;
    check($sformatf("latency[%0d]", idx), n, v.cyc);
    check($sformatf("writes[%0d]", idx), wrote, v.wr);
    check($sformatf("instret[%0d]", idx), instret, exp_instret);
  endtask

  initial begin
    logic [6:0]  opcs[8];
    logic [6:0]  opc;
    logic [31:0] ins;
    logic [15:0] e;
    logic        z;
    int          sel;

    vecs[0]  = '{32'h002081B3, 1'b0, 4, 4'h2, 1'b0, 1'b0, 1'b1}; // add
    vecs[1]  = '{32'h402081B3, 1'b0, 4, 4'h6, 1'b0, 1'b0, 1'b1}; // sub
    vecs[2]  = '{32'h0020F1B3, 1'b0, 4, 4'h0, 1'b0, 1'b0, 1'b1}; // and
    vecs[3]  = '{32'h0020E1B3, 1'b0, 4, 4'h1, 1'b0, 1'b0, 1'b1}; // or
    vecs[4]  = '{32'h0020A1B3, 1'b0, 4, 4'h7, 1'b0, 1'b0, 1'b1}; // slt
    vecs[5]  = '{32'h00508093, 1'b0, 4, 4'h2, 1'b0, 1'b0, 1'b1}; // addi
    vecs[6]  = '{32'h0050A093, 1'b0, 4, 4'h7, 1'b0, 1'b0, 1'b1}; // slti
    vecs[7]  = '{32'h0000A103, 1'b0, 5, 4'h2, 1'b0, 1'b0, 1'b1}; // lw
    vecs[8]  = '{32'h0020A023, 1'b0, 4, 4'h2, 1'b0, 1'b0, 1'b1}; // sw
    vecs[9]  = '{32'h00208463, 1'b1, 3, 4'h6, 1'b1, 1'b0, 1'b0}; // beq taken
    vecs[10] = '{32'h00208463, 1'b0, 3, 4'h6, 1'b0, 1'b0, 1'b0}; // beq not taken
    vecs[11] = '{32'h0080006F, 1'b0, 3, 4'h0, 1'b1, 1'b0, 1'b0}; // jal
    vecs[12] = '{32'h000080E7, 1'b0, 3, 4'h0, 1'b0, 1'b0, 1'b0}; // jalr
    vecs[13] = '{32'h000010B7, 1'b0, 3, 4'h0, 1'b0, 1'b0, 1'b1}; // lui
    vecs[14] = '{32'h0000007F, 1'b0, 2, 4'h0, 1'b0, 1'b1, 1'b0}; // unknown opcode
    vecs[15] = '{32'h002091B3, 1'b0, 2, 4'h0, 1'b0, 1'b1, 1'b0}; // R funct3=001
    vecs[16] = '{32'h00209463, 1'b1, 2, 4'h0, 1'b0, 1'b1, 1'b0}; // bne
    vecs[17] = '{32'h00109093, 1'b0, 2, 4'h0, 1'b0, 1'b1, 1'b0}; // I funct3=001

    // Reset held for three cycles, released just after an edge.
    rst = 1'b0; instruction = 32'h002081B3; zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", dut_vec, 0);
      check("reset_instret", instret, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 18; i++) apply_vec(vecs[i], i);

    // beq: pcsrc follows zero combinationally inside EXEC.
    instruction = 32'h00208463; zero = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    check("beq_zero0_pcsrc", pcsrc, 0);
    zero = 1'b1;
    #1;
    check("beq_zero1_pcsrc", pcsrc, 1);
    check("beq_exec_pc_en", pc_en, 1);
    @(posedge clk); #1;
    exp_instret++;

    // Reset while sw is in MEM: memwrite must drop before the next edge.
    instruction = 32'h0020A023; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    check("sw_mem_memwrite", memwrite, 1);
    rst = 1'b0;
    #1;
    check("abort_memwrite", memwrite, 0);
    check("abort_state", state, 0);
    check("abort_instret", instret, 0);
    exp_instret = 0;
    @(posedge clk); #1;
    check("abort_hold_memwrite", memwrite, 0);
    rst = 1'b1;
    apply_vec(vecs[8], 8);

    // Random instructions; the bus is scrambled after FETCH to exercise the field latch.
    opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h03; opcs[3] = 7'h23;
    opcs[4] = 7'h63; opcs[5] = 7'h6F; opcs[6] = 7'h67; opcs[7] = 7'h37;
    for (int t = 0; t < 80; t++) begin
      sel = $urandom_range(0, 9);
      opc = (sel < 8) ? opcs[sel] : 7'($urandom_range(0, 127));
      ins = $urandom;
      ins[6:0] = opc;
      if (opc == 7'h63 && $urandom_range(0, 1) == 1) ins[14:12] = 3'd0;
      z = 1'($urandom_range(0, 1));
      instruction = ins; zero = z;
      model_push(ins, z);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(negedge clk);
        check("rand_ctrl", dut_vec, e);
        check("rand_instret", instret, exp_instret);
        @(posedge clk); #1;
        if (e[11] && !e[4]) exp_instret++;
        instruction = $urandom;
      end
    end
    @(negedge clk);
    check("final_state", state, 0);
    check("final_instret", instret, exp_instret);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
